// File: rtl/sgpr_salu_wb_queue.sv
// sgpr_salu_wb_queue
//   Write-back buffer between the SALU and the SGPR SALU write port. SALU
//   results are queued and presented to the register-file arbiter; the head
//   entry is emitted on the SGPR write port when the SALU slot is granted.
//   Done-only entries drain without needing the port.
//   Optional feature macro: SALU_WB_BYPASS_EN (same-cycle forwarding when
//   the queue is empty).
module sgpr_salu_wb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned WFID_W = 6,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        salu_dest_wr_en,
  input  logic [ADDR_W-1:0] salu_dest_addr,
  input  logic [DATA_W-1:0] salu_dest_data,
  input  logic              salu_instr_done,
  input  logic [WFID_W-1:0] salu_instr_done_wfid,
  output logic              salu_wb_stall,
  output logic              rfa_req,
  input  logic              rfa_grant,
  output logic [1:0]        sgpr_wr_en,
  output logic [ADDR_W-1:0] sgpr_wr_addr,
  output logic [DATA_W-1:0] sgpr_wr_data,
  output logic              wb_instr_done,
  output logic [WFID_W-1:0] wb_instr_done_wfid,
  output logic [CNT_W-1:0]  wb_count,
  output logic              wb_overflow
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage (no reset; validity is tracked by count_q)
  logic [1:0]        wr_en_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem  [DEPTH];
  logic              done_mem  [DEPTH];
  logic [WFID_W-1:0] wfid_mem  [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic push_req;
  logic push_acc;
  logic head_valid;
  logic head_wr;
  logic full;
  logic pop;
`ifdef SALU_WB_BYPASS_EN
  logic byp_fire;
`endif

  // Push/pop decisions derived from registered head state
  always_comb begin
    push_req   = (|salu_dest_wr_en) | salu_instr_done;
    head_valid = (count_q != '0);
    head_wr    = |wr_en_mem[rd_ptr_q];
    full       = (count_q == FULL_CNT);
    pop        = head_valid & (~head_wr | rfa_grant);
`ifdef SALU_WB_BYPASS_EN
    // Empty queue: a done-only push forwards unconditionally, a write push
    // forwards only when granted; a forwarded push is never enqueued.
    byp_fire   = ~head_valid & push_req & (~(|salu_dest_wr_en) | rfa_grant);
    push_acc   = push_req & (~full | pop) & ~byp_fire;
`else
    push_acc   = push_req & (~full | pop);
`endif
  end

  // Next-state for pointers, occupancy and sticky overflow
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (push_req & full & ~pop);
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (push_acc && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push_acc) count_d = count_q - CNT_W'(1);
  end

  // Control state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage write on accepted push
  always_ff @(posedge clk) begin
    if (push_acc) begin
      wr_en_mem[wr_ptr_q] <= salu_dest_wr_en;
      addr_mem[wr_ptr_q]  <= salu_dest_addr;
      data_mem[wr_ptr_q]  <= salu_dest_data;
      done_mem[wr_ptr_q]  <= salu_instr_done;
      wfid_mem[wr_ptr_q]  <= salu_instr_done_wfid;
    end
  end

  // Output drive: enables only on a pop, fields held at head (0 when empty)
  always_comb begin
    salu_wb_stall      = full;
    wb_count           = count_q;
    wb_overflow        = ovf_q;
    rfa_req            = head_valid & head_wr;
    sgpr_wr_en         = pop ? wr_en_mem[rd_ptr_q] : 2'b00;
    sgpr_wr_addr       = head_valid ? addr_mem[rd_ptr_q] : '0;
    sgpr_wr_data       = head_valid ? data_mem[rd_ptr_q] : '0;
    wb_instr_done      = pop & done_mem[rd_ptr_q];
    wb_instr_done_wfid = head_valid ? wfid_mem[rd_ptr_q] : '0;
`ifdef SALU_WB_BYPASS_EN
    if (!head_valid) begin
      rfa_req = |salu_dest_wr_en;
      if (byp_fire) begin
        sgpr_wr_en         = salu_dest_wr_en;
        sgpr_wr_addr       = salu_dest_addr;
        sgpr_wr_data       = salu_dest_data;
        wb_instr_done      = salu_instr_done;
        wb_instr_done_wfid = salu_instr_done_wfid;
      end
    end
`endif
  end

endmodule

// File: tb/tb_sgpr_salu_wb_queue.sv
// Directed, table-driven bench for sgpr_salu_wb_queue (default parameters).
module tb_sgpr_salu_wb_queue;

`ifdef SALU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  wr_en;
  logic [8:0]  addr;
  logic [63:0] data;
  logic        done;
  logic [5:0]  wfid;
  logic        grant;
  logic        stall;
  logic        req;
  logic [1:0]  o_en;
  logic [8:0]  o_addr;
  logic [63:0] o_data;
  logic        o_done;
  logic [5:0]  o_wfid;
  logic [2:0]  o_cnt;
  logic        o_ovf;

  int pass_cnt = 0;
  int total_cnt = 0;

  sgpr_salu_wb_queue #(.DEPTH(4), .ADDR_W(9), .DATA_W(64), .WFID_W(6)) dut (
    .clk                  (clk),
    .rst                  (rst_n),
    .salu_dest_wr_en      (wr_en),
    .salu_dest_addr       (addr),
    .salu_dest_data       (data),
    .salu_instr_done      (done),
    .salu_instr_done_wfid (wfid),
    .salu_wb_stall        (stall),
    .rfa_req              (req),
    .rfa_grant            (grant),
    .sgpr_wr_en           (o_en),
    .sgpr_wr_addr         (o_addr),
    .sgpr_wr_data         (o_data),
    .wb_instr_done        (o_done),
    .wb_instr_done_wfid   (o_wfid),
    .wb_count             (o_cnt),
    .wb_overflow          (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wr_en;
    logic [8:0]  addr;
    logic [63:0] data;
    logic        done;
    logic [5:0]  wfid;
    logic        grant;
    logic [1:0]  e_en;
    logic [8:0]  e_addr;
    logic [63:0] e_data;
    logic        e_done;
    logic [5:0]  e_wfid;
    logic [2:0]  e_cnt;
    logic        e_req;
    logic        e_stall;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [1:0] wen, input logic [8:0] a, input logic [63:0] d,
    input logic dn, input logic [5:0] wf, input logic g,
    input logic [1:0] een, input logic [8:0] ea, input logic [63:0] ed,
    input logic edn, input logic [5:0] ewf, input logic [2:0] ec,
    input logic erq, input logic est, input logic eov);
    vec_t v;
    v.wr_en = wen; v.addr = a; v.data = d; v.done = dn; v.wfid = wf; v.grant = g;
    v.e_en = een; v.e_addr = ea; v.e_data = ed; v.e_done = edn; v.e_wfid = ewf;
    v.e_cnt = ec; v.e_req = erq; v.e_stall = est; v.e_ovf = eov;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic chk_all(input string tag, input logic [1:0] een, input logic [8:0] ea,
                         input logic [63:0] ed, input logic edn, input logic [5:0] ewf,
                         input logic [2:0] ec, input logic erq, input logic est,
                         input logic eov);
    chk({tag, ".wr_en"}, 64'(o_en),   64'(een));
    chk({tag, ".addr"},  64'(o_addr), 64'(ea));
    chk({tag, ".data"},  o_data,      ed);
    chk({tag, ".done"},  64'(o_done), 64'(edn));
    chk({tag, ".wfid"},  64'(o_wfid), 64'(ewf));
    chk({tag, ".count"}, 64'(o_cnt),  64'(ec));
    chk({tag, ".req"},   64'(req),    64'(erq));
    chk({tag, ".stall"}, 64'(stall),  64'(est));
    chk({tag, ".ovf"},   64'(o_ovf),  64'(eov));
  endtask

  task automatic drive(input logic [1:0] wen, input logic [8:0] a, input logic [63:0] d,
                       input logic dn, input logic [5:0] wf, input logic g);
    wr_en = wen; addr = a; data = d; done = dn; wfid = wf; grant = g;
  endtask

  task automatic idle(input logic g);
    drive(2'b00, 9'h000, 64'h0, 1'b0, 6'd0, g);
  endtask

  localparam logic [63:0] D1 = 64'h1111_0000_0000_0001;
  localparam logic [63:0] D2 = 64'h2222_0000_0000_0002;
  localparam logic [63:0] D3 = 64'h3333_0000_0000_0003;
  localparam logic [63:0] D4 = 64'h4444_0000_0000_0004;
  localparam logic [63:0] D5 = 64'h5555_0000_0000_0005;
  localparam logic [63:0] D6 = 64'h6666_0000_0000_0006;
  localparam logic [63:0] DA = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] DB = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] DX = 64'hDEAD_BEEF_0123_4567;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Fill order: inputs {wr_en, addr, data, done, wfid, grant},
    // expected {en, addr, data, done, wfid, count, req, stall, ovf}
    // Fill to full, push-with-pop while full, overflow drop, drain
    tbl.push_back(mk(2'b11, 9'h100, D1, 0, 6'd0,  0, 2'b00, 9'h000, 64'h0, 0, 6'd0, 3'd0, BYP, 0, 0));
    tbl.push_back(mk(2'b01, 9'h101, D2, 0, 6'd0,  0, 2'b00, 9'h100, D1,    0, 6'd0, 3'd1, 1, 0, 0));
    tbl.push_back(mk(2'b10, 9'h102, D3, 1, 6'd3,  0, 2'b00, 9'h100, D1,    0, 6'd0, 3'd2, 1, 0, 0));
    tbl.push_back(mk(2'b11, 9'h103, D4, 0, 6'd0,  0, 2'b00, 9'h100, D1,    0, 6'd0, 3'd3, 1, 0, 0));
    tbl.push_back(mk(2'b00, 9'h000, 0,  0, 6'd0,  0, 2'b00, 9'h100, D1,    0, 6'd0, 3'd4, 1, 1, 0));
    tbl.push_back(mk(2'b11, 9'h104, D5, 1, 6'd9,  1, 2'b11, 9'h100, D1,    0, 6'd0, 3'd4, 1, 1, 0));
    tbl.push_back(mk(2'b00, 9'h000, 0,  0, 6'd0,  0, 2'b00, 9'h101, D2,    0, 6'd0, 3'd4, 1, 1, 0));
    tbl.push_back(mk(2'b11, 9'h1FF, D6, 1, 6'd63, 0, 2'b00, 9'h101, D2,    0, 6'd0, 3'd4, 1, 1, 0));
    tbl.push_back(mk(2'b00, 9'h000, 0,  0, 6'd0,  0, 2'b00, 9'h101, D2,    0, 6'd0, 3'd4, 1, 1, 1));
    tbl.push_back(mk(2'b00, 9'h000, 0,  0, 6'd0,  1, 2'b01, 9'h101, D2,    0, 6'd0, 3'd4, 1, 1, 1));
    tbl.push_back(mk(2'b00, 9'h000, 0,  0, 6'd0,  1, 2'b10, 9'h102, D3,    1, 6'd3, 3'd3, 1, 0, 1));
    tbl.push_back(mk(2'b00, 9'h000, 0,  0, 6'd0,  1, 2'b11, 9'h103, D4,    0, 6'd0, 3'd2, 1, 0, 1));
    tbl.push_back(mk(2'b00, 9'h000, 0,  0, 6'd0,  1, 2'b11, 9'h104, D5,    1, 6'd9, 3'd1, 1, 0, 1));
    tbl.push_back(mk(2'b00, 9'h000, 0,  0, 6'd0,  1, 2'b00, 9'h000, 64'h0, 0, 6'd0, 3'd0, 0, 0, 1));
    // Ordering: write A, done-only wfid 7, write B; grant withheld 3 cycles
    tbl.push_back(mk(2'b11, 9'h020, DA, 0, 6'd2,  0, 2'b00, 9'h000, 64'h0, 0, 6'd0, 3'd0, BYP, 0, 1));
    tbl.push_back(mk(2'b00, 9'h000, 0,  1, 6'd7,  0, 2'b00, 9'h020, DA,    0, 6'd2, 3'd1, 1, 0, 1));
    tbl.push_back(mk(2'b11, 9'h021, DB, 0, 6'd0,  0, 2'b00, 9'h020, DA,    0, 6'd2, 3'd2, 1, 0, 1));
    tbl.push_back(mk(2'b00, 9'h000, 0,  0, 6'd0,  0, 2'b00, 9'h020, DA,    0, 6'd2, 3'd3, 1, 0, 1));
    tbl.push_back(mk(2'b00, 9'h000, 0,  0, 6'd0,  1, 2'b11, 9'h020, DA,    0, 6'd2, 3'd3, 1, 0, 1));
    tbl.push_back(mk(2'b00, 9'h000, 0,  0, 6'd0,  0, 2'b00, 9'h000, 64'h0, 1, 6'd7, 3'd2, 0, 0, 1));
    tbl.push_back(mk(2'b00, 9'h000, 0,  0, 6'd0,  0, 2'b00, 9'h021, DB,    0, 6'd0, 3'd1, 1, 0, 1));
    tbl.push_back(mk(2'b00, 9'h000, 0,  0, 6'd0,  1, 2'b11, 9'h021, DB,    0, 6'd0, 3'd1, 1, 0, 1));
    tbl.push_back(mk(2'b00, 9'h000, 0,  0, 6'd0,  0, 2'b00, 9'h000, 64'h0, 0, 6'd0, 3'd0, 0, 0, 1));

    rst_n = 1'b0;
    idle(1'b0);
    repeat (2) @(negedge clk);
    #1 chk_all("reset", 2'b00, 9'h000, 64'h0, 0, 6'd0, 3'd0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single push with grant held: 1-cycle latency (0-cycle under bypass)
    @(negedge clk);
    drive(2'b11, 9'h010, DX, 1'b1, 6'd5, 1'b1);
    #1;
    if (BYP) chk_all("p1.c0", 2'b11, 9'h010, DX, 1, 6'd5, 3'd0, 1, 0, 0);
    else     chk_all("p1.c0", 2'b00, 9'h000, 64'h0, 0, 6'd0, 3'd0, 0, 0, 0);
    @(negedge clk);
    idle(1'b1);
    #1;
    if (BYP) chk_all("p1.c1", 2'b00, 9'h000, 64'h0, 0, 6'd0, 3'd0, 0, 0, 0);
    else     chk_all("p1.c1", 2'b11, 9'h010, DX, 1, 6'd5, 3'd1, 1, 0, 0);
    @(negedge clk);
    drive(2'b11, 9'h030, D6, 1'b0, 6'd0, 1'b1);
    #1;
    if (BYP) chk_all("p2.c0", 2'b11, 9'h030, D6, 0, 6'd0, 3'd0, 1, 0, 0);
    else     chk_all("p2.c0", 2'b00, 9'h000, 64'h0, 0, 6'd0, 3'd0, 0, 0, 0);
    @(negedge clk);
    idle(1'b1);
    #1;
    if (BYP) chk_all("p2.c1", 2'b00, 9'h000, 64'h0, 0, 6'd0, 3'd0, 0, 0, 0);
    else     chk_all("p2.c1", 2'b11, 9'h030, D6, 0, 6'd0, 3'd1, 1, 0, 0);
    @(negedge clk);
    idle(1'b0);
    #1 chk_all("p2.c2", 2'b00, 9'h000, 64'h0, 0, 6'd0, 3'd0, 0, 0, 0);

    // Table-driven sequences
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].wr_en, tbl[i].addr, tbl[i].data, tbl[i].done, tbl[i].wfid, tbl[i].grant);
      #1 chk_all($sformatf("vec%0d", i), tbl[i].e_en, tbl[i].e_addr, tbl[i].e_data,
                 tbl[i].e_done, tbl[i].e_wfid, tbl[i].e_cnt, tbl[i].e_req,
                 tbl[i].e_stall, tbl[i].e_ovf);
    end

    // Asynchronous reset mid-drain discards queued entries
    @(negedge clk);
    drive(2'b11, 9'h040, D1, 1'b0, 6'd1, 1'b0);
    @(negedge clk);
    drive(2'b11, 9'h041, D2, 1'b1, 6'd2, 1'b0);
    @(negedge clk);
    drive(2'b11, 9'h042, D3, 1'b0, 6'd3, 1'b0);
    @(negedge clk);
    idle(1'b1);
    #1 chk_all("rst.pre", 2'b11, 9'h040, D1, 0, 6'd1, 3'd3, 1, 0, 1);
    #2 rst_n = 1'b0;
    #1 chk_all("rst.async", 2'b00, 9'h000, 64'h0, 0, 6'd0, 3'd0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle(1'b1);
      #1 chk_all($sformatf("rst.post%0d", c), 2'b00, 9'h000, 64'h0, 0, 6'd0, 3'd0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sgpr_salu_wb_queue.md
Name: sgpr_salu_wb_queue

Overview:
Write-back buffer between the SALU and the SGPR write-port mux. It captures each SALU result (dest write and/or instr-done) into a small FIFO and raises a request to the register-file arbiter (RFA). When the RFA grants the SALU slot, it drives the head entry onto the SGPR SALU write-port inputs and the issue-side done signals. This decouples SALU completion from single-write-port contention with the SIMD/SIMF and LSU writers.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
ADDR_W, 9, SGPR address width
DATA_W, 64, write data width (2 x 32b SGPRs)
WFID_W, 6, wavefront id width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
salu_dest_wr_en  in  2  per-dword write enable from SALU
salu_dest_addr  in  ADDR_W  SALU destination SGPR address
salu_dest_data  in  DATA_W  SALU result
salu_instr_done  in  1  SALU instruction complete
salu_instr_done_wfid  in  WFID_W  wavefront of completing instruction
salu_wb_stall  out  1  back-pressure to SALU; high when count==DEPTH
rfa_req  out  1  request for the SGPR write port
rfa_grant  in  1  SALU slot selected by RFA (rfa_select_fu bit for SALU)
sgpr_wr_en  out  2  write enable to SGPR SALU port
sgpr_wr_addr  out  ADDR_W  write address to SGPR
sgpr_wr_data  out  DATA_W  write data to SGPR
wb_instr_done  out  1  instr-done toward issue
wb_instr_done_wfid  out  WFID_W  wfid toward issue
wb_count  out  clog2(DEPTH+1)  current occupancy
wb_overflow  out  1  sticky protocol-violation flag

Behaviour:
- Push: occurs when (|salu_dest_wr_en) | salu_instr_done. One entry stores {wr_en, addr, data, done, wfid}.
- Head entry types:
  - Write entry (wr_en!=0): needs the write port.
  - Done-only entry (wr_en==0, done=1): needs no port.
- rfa_req = valid head & head.wr_en!=0. Request is combinational from head state only, never from incoming push (except under optional feature).
- Pop conditions:
  - Write entry: pops when rfa_grant=1 in the same cycle.
  - Done-only entry: pops unconditionally in the cycle it is at the head.
- Outputs during a pop cycle: sgpr_wr_* = head fields, wb_instr_done = head.done, wb_instr_done_wfid = head.wfid.
- Outputs in non-pop cycles: all output enables 0. Addr/data/wfid are held at the head value, or 0 when empty.
- Ordering: at most one pop per cycle, strict FIFO order. A done-only entry never overtakes an earlier write entry.
- Latency: a push is visible at the head the next cycle. Minimum push-to-SGPR-write latency is 1 cycle.
- rfa_grant while rfa_req=0: ignored; no pop and no state change.
- Occupancy:
  - wb_count +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Full:
  - salu_wb_stall = (wb_count==DEPTH), computed from registered count.
  - Push while full with a simultaneous pop: accepted.
  - Push while full without a pop: entry dropped, wb_overflow set and held until reset.
- Empty: rfa_req=0 and all output enables 0. Simultaneous push and grant while empty: grant ignored, entry enqueued.
- Reset (rst low, asynchronous): pointers, count, and all valid state clear; all outputs 0; wb_overflow=0. Reset mid-operation discards all queued entries with no partial write. Entry storage arrays need no reset.

Optional Feature:
Macro: SALU_WB_BYPASS_EN
- Defined: when wb_count==0 and an incoming push carries a write, rfa_req asserts combinationally from the input. If rfa_grant=1 that cycle, the entry is forwarded directly to sgpr_wr_*/wb_instr_done with 0-cycle latency and not enqueued. A done-only push while empty is also forwarded same cycle. Count is unchanged.
- Not defined: no bypass; behaviour as above with a 1-cycle minimum latency. Bypass logic must be absent from the netlist.

Test Plan:
- Reset then single push {wr_en=2'b11, addr=9'h010, data=64'hDEAD_BEEF_0123_4567, done=1, wfid=5} with grant held 1 -> cycle+1: sgpr_wr_en=2'b11, addr=9'h010, data matches, wb_instr_done=1, wfid=5; wb_count returns to 0.
- Push 4 write entries with grant=0 -> wb_count=4, salu_wb_stall=1, rfa_req=1. Then 5th push with grant=1 in the same cycle -> head written, 5th accepted, wb_count=4, wb_overflow=0.
- Full, grant=0, push -> wb_overflow=1 and sticky; the dropped entry never appears on sgpr_wr_*.
- Sequence: write A (addr 9'h020), done-only (wfid=7), write B (addr 9'h021), grant=0 for 3 cycles then 1 -> rfa_req=1 throughout. Output order: A write, then done wfid=7 alone with sgpr_wr_en=0 and no grant needed, then B after next grant.
- Queue 3 entries, deassert rst mid-drain -> all outputs 0 immediately (asynchronous), wb_count=0 after release, no stale entries emitted.
- With SALU_WB_BYPASS_EN: empty queue, push write addr 9'h030 with grant=1 -> same-cycle sgpr_wr_en=2'b11, addr=9'h030, wb_count stays 0. Without the macro, the same stimulus writes at cycle+1.
